// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the configurable UART transmit path.
package uart_pkg;

   localparam int DIV_W = 16;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      EVEN = 2'b01,
      ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   function automatic logic [DIV_W-1:0] default_div(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
      if (baud_rate == 32'd0) begin
         return DIV_W'(2);
      end else begin
         return DIV_W'(clk_freq / baud_rate);
      end
   endfunction

   // Encoding 2'b11 is treated as "no parity", same as 2'b00.
   function automatic parity_e decode_parity(input logic [1:0] cfg);
      case (cfg)
         2'b01:   return EVEN;
         2'b10:   return ODD;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word stream feeding the UART transmitter.
interface uart_tx_cfg_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == CNT_W'(0));
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with TX FIFO; parity, stop bits and
// divisor are sampled when a word is popped and held for that whole frame.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          FIFO_DEPTH = 8,
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   uart_tx_cfg_if.slave                  s_if,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic [DIV_W-1:0]              cfg_div,
   output logic                          TxD,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int               IDX_W   = $clog2(DATA_WIDTH);
   localparam logic [DIV_W-1:0] DEF_DIV = default_div(CLK_FREQ, BAUD_RATE);

   logic                  push_s, pop_s, full_s, empty_s;
   logic [DATA_WIDTH-1:0] head_s;
   logic [CNT_W-1:0]      cnt_s, cnt_nxt_s;
   logic [DIV_W-1:0]      eff_div_s;
   parity_e               pmode_in_s;
   logic                  baud_last_s;

   tx_state_e             state_r, state_nxt;
   logic [DATA_WIDTH-1:0] data_r, data_nxt;
   logic [IDX_W-1:0]      idx_r, idx_nxt, sel_s;
   logic [DIV_W-1:0]      baud_r, baud_nxt, div_r, div_nxt;
   parity_e               pmode_r, pmode_nxt;
   logic                  pbit_r, pbit_nxt;
   logic                  stop2_r, stop2_nxt, stop_sec_r, stop_sec_nxt;

   logic                  txd_r, txd_nxt, done_r, done_nxt, busy_r, busy_nxt, s_ready_r;

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .wdata   (s_if.s_data),
      .pop     (pop_s),
      .rdata   (head_s),
      .full    (full_s),
      .empty   (empty_s),
      .count   (cnt_s)
   );

   assign push_s      = s_if.s_valid & s_ready_r & ~full_s;
   assign eff_div_s   = (cfg_div < DIV_W'(2)) ? DEF_DIV : cfg_div;
   assign pmode_in_s  = decode_parity(cfg_parity);
   assign baud_last_s = (baud_r == {DIV_W{1'b0}});

   assign s_if.s_ready = s_ready_r;
   assign TxD          = txd_r;
   assign busy         = busy_r;
   assign tx_done      = done_r;
   assign fifo_count   = cnt_s;

   // Occupancy after the current edge, used for the registered s_ready and busy.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_s + CNT_W'(1);
         2'b01:   cnt_nxt_s = cnt_s - CNT_W'(1);
         default: cnt_nxt_s = cnt_s;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         data_r     <= {DATA_WIDTH{1'b0}};
         idx_r      <= IDX_W'(0);
         baud_r     <= {DIV_W{1'b0}};
         div_r      <= DEF_DIV;
         pmode_r    <= NONE;
         pbit_r     <= 1'b0;
         stop2_r    <= 1'b0;
         stop_sec_r <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         data_r     <= data_nxt;
         idx_r      <= idx_nxt;
         baud_r     <= baud_nxt;
         div_r      <= div_nxt;
         pmode_r    <= pmode_nxt;
         pbit_r     <= pbit_nxt;
         stop2_r    <= stop2_nxt;
         stop_sec_r <= stop_sec_nxt;
      end
   end

   // FSM next-state; a pop loads the head word and this frame's configuration.
   always_comb begin
      state_nxt    = state_r;
      idx_nxt      = idx_r;
      baud_nxt     = baud_r;
      stop_sec_nxt = stop_sec_r;
      pop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s     = 1'b1;
               state_nxt = START;
            end else begin
               state_nxt = IDLE;
            end
         end
         START: begin
            if (baud_last_s) begin
               state_nxt = DATA;
               idx_nxt   = IDX_W'(0);
               baud_nxt  = div_r - DIV_W'(1);
            end else begin
               baud_nxt  = baud_r - DIV_W'(1);
            end
         end
         DATA: begin
            if (baud_last_s) begin
               baud_nxt = div_r - DIV_W'(1);
               if (idx_r == IDX_W'(DATA_WIDTH - 1)) begin
                  if (pmode_r == NONE) begin
                     state_nxt    = STOP;
                     stop_sec_nxt = 1'b0;
                  end else begin
                     state_nxt    = PARITY;
                  end
               end else begin
                  idx_nxt = idx_r + IDX_W'(1);
               end
            end else begin
               baud_nxt = baud_r - DIV_W'(1);
            end
         end
         PARITY: begin
            if (baud_last_s) begin
               state_nxt    = STOP;
               stop_sec_nxt = 1'b0;
               baud_nxt     = div_r - DIV_W'(1);
            end else begin
               baud_nxt     = baud_r - DIV_W'(1);
            end
         end
         STOP: begin
            if (baud_last_s) begin
               if (stop2_r && !stop_sec_r) begin
                  stop_sec_nxt = 1'b1;
                  baud_nxt     = div_r - DIV_W'(1);
               end else if (!empty_s) begin
                  pop_s        = 1'b1;
                  state_nxt    = START;
               end else begin
                  state_nxt    = IDLE;
               end
            end else begin
               baud_nxt = baud_r - DIV_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (pop_s) begin
         data_nxt     = head_s;
         div_nxt      = eff_div_s;
         baud_nxt     = eff_div_s - DIV_W'(1);
         pmode_nxt    = pmode_in_s;
         pbit_nxt     = (pmode_in_s == ODD) ? ~(^head_s) : (^head_s);
         stop2_nxt    = cfg_stop2;
         stop_sec_nxt = 1'b0;
         idx_nxt      = IDX_W'(0);
      end else begin
         data_nxt     = data_r;
         div_nxt      = div_r;
         pmode_nxt    = pmode_r;
         pbit_nxt     = pbit_r;
         stop2_nxt    = stop2_r;
      end
   end

   // FSM outputs, computed from next-state so the registered TxD lines up with the state.
   always_comb begin
      sel_s = MSB_FIRST ? (IDX_W'(DATA_WIDTH - 1) - idx_nxt) : idx_nxt;
      case (state_nxt)
         IDLE:    txd_nxt = 1'b1;
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = data_nxt[sel_s];
         PARITY:  txd_nxt = pbit_nxt;
         STOP:    txd_nxt = 1'b1;
         default: txd_nxt = 1'b1;
      endcase
      done_nxt = (state_nxt == STOP) && (baud_nxt == {DIV_W{1'b0}}) &&
                 (!stop2_nxt || stop_sec_nxt);
      busy_nxt = (state_nxt != IDLE) || (cnt_nxt_s != CNT_W'(0));
   end

   // Output registers; reset forces the line idle immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         txd_r     <= 1'b1;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
         s_ready_r <= 1'b0;
      end else begin
         txd_r     <= txd_nxt;
         done_r    <= done_nxt;
         busy_r    <= busy_nxt;
         s_ready_r <= (cnt_nxt_s < CNT_W'(FIFO_DEPTH));
      end
   end

endmodule
